// File: rtl/present_pkg.sv
// Shared types and datapath helpers for the PRESENT cipher core:
// block geometry, FSM encoding, substitution and permutation layers.
package present_pkg;

  localparam int BLOCK_SIZE = 64;
  localparam int NUM_ROUNDS = 31;

  typedef enum logic [2:0] {
    IDLE,
    KEYEXP,
    ROUND,
    FINAL,
    DONE
  } state_e;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  function automatic logic [BLOCK_SIZE-1:0] sbox_layer(input logic [BLOCK_SIZE-1:0] s);
    logic [BLOCK_SIZE-1:0] r;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = sbox4(s[4*n +: 4]);
    return r;
  endfunction

  function automatic logic [BLOCK_SIZE-1:0] inv_sbox_layer(input logic [BLOCK_SIZE-1:0] s);
    logic [BLOCK_SIZE-1:0] r;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = inv_sbox4(s[4*n +: 4]);
    return r;
  endfunction

  // Bit b moves to position 16*b mod 63; bit 63 stays in place.
  function automatic logic [BLOCK_SIZE-1:0] p_layer(input logic [BLOCK_SIZE-1:0] s);
    logic [BLOCK_SIZE-1:0] r;
    for (int b = 0; b < 63; b++) r[(b * 16) % 63] = s[b];
    r[63] = s[63];
    return r;
  endfunction

  function automatic logic [BLOCK_SIZE-1:0] inv_p_layer(input logic [BLOCK_SIZE-1:0] s);
    logic [BLOCK_SIZE-1:0] r;
    for (int b = 0; b < 63; b++) r[b] = s[(b * 16) % 63];
    r[63] = s[63];
    return r;
  endfunction

endpackage

// File: rtl/present_key_step.sv
// One forward or inverse step of the PRESENT key schedule for an
// 80- or 128-bit key register. Purely combinational.
module present_key_step
  import present_pkg::*;
#(
  parameter int KEY_SIZE = 80
) (
  input  logic [KEY_SIZE-1:0] key_i,
  input  logic [4:0]          round_i,
  input  logic                inverse_i,
  output logic [KEY_SIZE-1:0] key_o
);

  // Position of the 5-bit round-counter injection.
  localparam int CNT_LSB = (KEY_SIZE == 128) ? 62 : 15;

  logic [KEY_SIZE-1:0] fwd_key;
  logic [KEY_SIZE-1:0] inv_tmp;
  logic [KEY_SIZE-1:0] inv_key;

  // Forward: rotate left 61, substitute top nibble(s), inject counter.
  always_comb begin
    fwd_key = {key_i[KEY_SIZE-62:0], key_i[KEY_SIZE-1:KEY_SIZE-61]};
    fwd_key[KEY_SIZE-1 -: 4] = sbox4(fwd_key[KEY_SIZE-1 -: 4]);
    if (KEY_SIZE == 128) fwd_key[KEY_SIZE-5 -: 4] = sbox4(fwd_key[KEY_SIZE-5 -: 4]);
    fwd_key[CNT_LSB +: 5] = fwd_key[CNT_LSB +: 5] ^ round_i;
  end

  // Inverse: undo the forward step in reverse order.
  always_comb begin
    inv_tmp = key_i;
    inv_tmp[CNT_LSB +: 5] = inv_tmp[CNT_LSB +: 5] ^ round_i;
    inv_tmp[KEY_SIZE-1 -: 4] = inv_sbox4(inv_tmp[KEY_SIZE-1 -: 4]);
    if (KEY_SIZE == 128) inv_tmp[KEY_SIZE-5 -: 4] = inv_sbox4(inv_tmp[KEY_SIZE-5 -: 4]);
    inv_key = {inv_tmp[60:0], inv_tmp[KEY_SIZE-1:61]};
  end

  assign key_o = inverse_i ? inv_key : fwd_key;

endmodule

// File: rtl/present_codec.sv
// Iterative PRESENT encrypt/decrypt core, one round per clock, with
// valid/ready handshakes on both the job input and the result output.
module present_codec
  import present_pkg::*;
#(
  parameter int KEY_SIZE = 80
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  decrypt,
  input  logic [KEY_SIZE-1:0]   key_in,
  input  logic [BLOCK_SIZE-1:0] data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BLOCK_SIZE-1:0] data_out,
  output logic                  busy
);

  if (KEY_SIZE != 80 && KEY_SIZE != 128) begin : g_bad_key_size
    $error("present_codec: KEY_SIZE must be 80 or 128");
  end

  state_e                fsm_q, fsm_d;
  logic [4:0]            round_q, round_d;
  logic                  dec_q, dec_d;
  logic [KEY_SIZE-1:0]   key_q, key_d;
  logic [BLOCK_SIZE-1:0] blk_q, blk_d;

  logic [KEY_SIZE-1:0]   step_key;
  logic [BLOCK_SIZE-1:0] step_rk;
  logic [BLOCK_SIZE-1:0] cur_rk;

  // Decrypt rounds walk the schedule backwards; everything else steps forward.
  present_key_step #(.KEY_SIZE(KEY_SIZE)) u_key_step (
    .key_i     (key_q),
    .round_i   (round_q),
    .inverse_i ((fsm_q == ROUND) && dec_q),
    .key_o     (step_key)
  );

  assign cur_rk  = key_q[KEY_SIZE-1 -: BLOCK_SIZE];
  assign step_rk = step_key[KEY_SIZE-1 -: BLOCK_SIZE];

  // Next-state logic: FSM, round counter, cipher state and key register.
  // NOTE: every target gets a default first so no path leaves one unassigned and infers a latch.
  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    dec_d   = dec_q;
    key_d   = key_q;
    blk_d   = blk_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          blk_d   = data_in;
          key_d   = key_in;
          dec_d   = decrypt;
          round_d = 5'd1;
          fsm_d   = decrypt ? KEYEXP : ROUND;
        end
      end
      KEYEXP: begin
        key_d = step_key;
        if (round_q == 5'(NUM_ROUNDS)) begin
          // Register now holds K32: whiten the ciphertext and start unwinding.
          blk_d = blk_q ^ step_rk;
          fsm_d = ROUND;
        end else begin
          round_d = round_q + 5'd1;
        end
      end
      ROUND: begin
        key_d = step_key;
        if (dec_q) begin
          blk_d = inv_sbox_layer(inv_p_layer(blk_q)) ^ step_rk;
          if (round_q == 5'd1) fsm_d = DONE;
          else                 round_d = round_q - 5'd1;
        end else begin
          blk_d = p_layer(sbox_layer(blk_q ^ cur_rk));
          if (round_q == 5'(NUM_ROUNDS)) fsm_d = FINAL;
          else                           round_d = round_q + 5'd1;
        end
      end
      FINAL: begin
        blk_d = blk_q ^ cur_rk;
        fsm_d = DONE;
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // State registers; reset aborts any job in flight.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      fsm_q   <= IDLE;
      round_q <= '0;
      dec_q   <= 1'b0;
      key_q   <= '0;
      blk_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      dec_q   <= dec_d;
      key_q   <= key_d;
      blk_q   <= blk_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);
  // Intermediate round state is not exposed; only the finished block is.
  assign data_out  = out_valid ? blk_q : '0;

endmodule

// File: tb/tb_present_codec.sv
// Bench for present_codec: an 80-bit and a 128-bit instance run in lockstep
// on shared handshake/mode signals; a scoreboard queue holds expected results
// computed by a round-key-list reference model.
module tb_present_codec;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        decrypt = 1'b0;
  logic        out_ready = 1'b1;
  logic [79:0]  key80 = '0;
  logic [127:0] key128 = '0;
  logic [63:0]  din80 = '0;
  logic [63:0]  din128 = '0;

  logic        in_ready80, out_valid80, busy80;
  logic        in_ready128, out_valid128, busy128;
  logic [63:0] dout80, dout128;

  always #5 Clock = ~Clock;

  present_codec #(.KEY_SIZE(80)) dut80 (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready80),
    .decrypt(decrypt), .key_in(key80), .data_in(din80), .out_valid(out_valid80),
    .out_ready(out_ready), .data_out(dout80), .busy(busy80)
  );

  present_codec #(.KEY_SIZE(128)) dut128 (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready128),
    .decrypt(decrypt), .key_in(key128), .data_in(din128), .out_valid(out_valid128),
    .out_ready(out_ready), .data_out(dout128), .busy(busy128)
  );

  // ---------------- reference model ----------------
  localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  function automatic logic [3:0] inv_sb(input logic [3:0] v);
    logic [3:0] r = '0;
    for (int x = 0; x < 16; x++) if (SB[x] == v) r = 4'(x);
    return r;
  endfunction

  function automatic logic [63:0] subst(input logic [63:0] s, input bit inv);
    logic [63:0] t;
    for (int n = 0; n < 16; n++) t[4*n +: 4] = inv ? inv_sb(s[4*n +: 4]) : SB[s[4*n +: 4]];
    return t;
  endfunction

  function automatic logic [63:0] perm(input logic [63:0] s, input bit inv);
    logic [63:0] t;
    int dest;
    for (int b = 0; b < 64; b++) begin
      dest = (b == 63) ? 63 : (b * 16) % 63;
      if (inv) t[b] = s[dest];
      else     t[dest] = s[b];
    end
    return t;
  endfunction

  function automatic logic [63:0] model(input bit dec, input int w,
                                        input logic [127:0] key, input logic [63:0] din);
    logic [63:0]  rk [1:32];
    logic [127:0] k, mask;
    logic [63:0]  s;
    mask = (w == 128) ? '1 : ((128'd1 << 80) - 128'd1);
    k = key & mask;
    for (int i = 1; i <= 32; i++) begin
      rk[i] = k[w-64 +: 64];
      if (i < 32) begin
        k = ((k << 61) | (k >> (w - 61))) & mask;
        k[w-4 +: 4] = SB[k[w-4 +: 4]];
        if (w == 128) k[w-8 +: 4] = SB[k[w-8 +: 4]];
        k = k ^ (128'(i) << ((w == 128) ? 62 : 15));
      end
    end
    if (!dec) begin
      s = din;
      for (int i = 1; i <= 31; i++) s = perm(subst(s ^ rk[i], 1'b0), 1'b0);
      s = s ^ rk[32];
    end else begin
      s = din ^ rk[32];
      for (int i = 31; i >= 1; i--) s = subst(perm(s, 1'b1), 1'b1) ^ rk[i];
    end
    return s;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [63:0] e80;
    logic [63:0] e128;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per result handshake.
  always @(negedge Clock) begin
    if (Reset && out_valid80 && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 128'(out_valid80), 128'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("data_out80", 128'(dout80), 128'(e.e80));
        check("data_out128", 128'(dout128), 128'(e.e128));
        check("out_valid128", 128'(out_valid128), 128'(1));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_job(input bit dec, input logic [79:0] k80, input logic [127:0] k128,
                         input logic [63:0] d80, input logic [63:0] d128,
                         input logic [63:0] e80, input logic [63:0] e128, input int hold);
    int   n;
    exp_t x;
    n = 0;
    while (!(in_ready80 && in_ready128) && n < 100) begin
      @(posedge Clock); #1; n++;
    end
    check("ready_before_job", 128'({in_ready80, in_ready128}), 128'(2'b11));
    out_ready = (hold == 0);
    in_valid = 1'b1; decrypt = dec; key80 = k80; key128 = k128; din80 = d80; din128 = d128;
    @(posedge Clock); #1;
    x.e80 = e80; x.e128 = e128;
    sb_q.push_back(x);
    // Scramble inputs after accept; the captured job must be unaffected.
    in_valid = 1'b0;
    decrypt = 1'($urandom);
    key80 = 80'({$urandom, $urandom, $urandom});
    key128 = {$urandom, $urandom, $urandom, $urandom};
    din80 = {$urandom, $urandom};
    din128 = {$urandom, $urandom};
    check("busy_after_accept", 128'({busy80, busy128}), 128'(2'b11));
    n = 0;
    while (!(out_valid80 || out_valid128) && n < 100) begin
      @(posedge Clock); #1; n++;
    end
    check("latency", 128'(n), 128'(dec ? 62 : 32));
    check("valid_pair", 128'({out_valid80, out_valid128}), 128'(2'b11));
    if (hold > 0) begin
      for (int c = 0; c < hold; c++) begin
        in_valid = 1'($urandom_range(0, 1));
        @(posedge Clock); #1;
        check("hold_data80", 128'(dout80), 128'(e80));
        check("hold_data128", 128'(dout128), 128'(e128));
        check("hold_in_ready", 128'({in_ready80, in_ready128}), 128'(0));
        check("hold_out_valid", 128'({out_valid80, out_valid128}), 128'(2'b11));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge Clock); #1;
    check("in_ready_after_take", 128'({in_ready80, in_ready128}), 128'(2'b11));
    check("out_valid_after_take", 128'({out_valid80, out_valid128}), 128'(0));
  endtask

  initial begin
    bit           dec;
    logic [79:0]  k80;
    logic [127:0] k128;
    logic [63:0]  d80, d128;

    // Reset values
    repeat (2) @(negedge Clock);
    check("rst_in_ready", 128'({in_ready80, in_ready128}), 128'(2'b11));
    check("rst_out_valid", 128'({out_valid80, out_valid128}), 128'(0));
    check("rst_busy", 128'({busy80, busy128}), 128'(0));
    check("rst_data_out", {dout80, dout128}, 128'(0));
    Reset = 1'b1;
    @(negedge Clock);

    // Known answers: zero key/zero block on both widths
    run_job(1'b0, '0, '0, '0, '0, 64'h5579C1387B228445, 64'h96DB702A2E6900AF, 0);
    // All-ones 80-bit encrypt with back-pressure; 128-bit side random
    k128 = {$urandom, $urandom, $urandom, $urandom};
    d128 = {$urandom, $urandom};
    run_job(1'b0, '1, k128, '1, d128, 64'h3333DCD3213210D2, model(1'b0, 128, k128, d128), 10);
    // Known-answer decrypts
    run_job(1'b1, '1, '0, 64'h3333DCD3213210D2, 64'h96DB702A2E6900AF,
            64'hFFFFFFFFFFFFFFFF, 64'h0, 0);

    // Abort mid-job with an asynchronous reset
    out_ready = 1'b1;
    in_valid = 1'b1; decrypt = 1'b0; key80 = '0; key128 = '0; din80 = '0; din128 = '0;
    @(posedge Clock); #1;
    in_valid = 1'b0;
    repeat (14) @(posedge Clock);
    #1;
    check("busy_before_abort", 128'({busy80, busy128}), 128'(2'b11));
    Reset = 1'b0;
    #1;
    check("abort_in_ready", 128'({in_ready80, in_ready128}), 128'(2'b11));
    check("abort_out_valid", 128'({out_valid80, out_valid128}), 128'(0));
    check("abort_busy", 128'({busy80, busy128}), 128'(0));
    check("abort_data_out", {dout80, dout128}, 128'(0));
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    run_job(1'b0, '0, '0, '0, '0, 64'h5579C1387B228445, 64'h96DB702A2E6900AF, 0);

    // Randomized jobs against the model
    for (int j = 0; j < 8; j++) begin
      dec  = 1'($urandom);
      k80  = 80'({$urandom, $urandom, $urandom});
      k128 = {$urandom, $urandom, $urandom, $urandom};
      d80  = {$urandom, $urandom};
      d128 = {$urandom, $urandom};
      run_job(dec, k80, k128, d80, d128,
              model(dec, 80, 128'(k80), d80), model(dec, 128, k128, d128),
              (j == 3) ? 3 : 0);
    end

    repeat (5) @(posedge Clock);
    check("scoreboard_empty", 128'(sb_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/present_codec.md
# present_codec

Iterative PRESENT block-cipher core with both encryption and decryption, for 80-bit or 128-bit keys. Each job is a 64-bit block, a key and a mode bit, accepted over a valid/ready handshake. The core runs one round per clock and returns the result over a second valid/ready handshake. It replaces the fixed 80-bit, encrypt-only, Enable/Done round engine in the security datapath. It also adds decryption and back-pressure.

## Interface
- `KEY_SIZE`, 80, key width; only 80 or 128 are legal (elaboration error otherwise)
- `Clock` input 1, single clock, rising edge
- `Reset` input 1, asynchronous, active-low
- `in_valid` input 1, job offered
- `in_ready` output 1, core can accept a job; high only in IDLE
- `decrypt` input 1, mode: 0 = encrypt, 1 = decrypt; sampled on accept
- `key_in` input KEY_SIZE, cipher key; sampled on accept
- `data_in` input 64, plaintext or ciphertext; sampled on accept
- `out_valid` output 1, result available
- `out_ready` input 1, consumer takes result
- `data_out` output 64, result; stable while `out_valid` is high
- `busy` output 1, high in every state except IDLE

## Operation
- Accept: `in_valid && in_ready` at a rising edge. The block, key and mode are captured into internal registers. Later changes on the inputs are ignored until the next accept.
- Round key K_i is the top 64 bits of the key register.
- Key step, 80-bit:
  - rotate left 61;
  - S-box on bits [79:76];
  - XOR round counter i into bits [19:15].
- Key step, 128-bit:
  - rotate left 61;
  - S-box on bits [127:124] and [123:120];
  - XOR i into bits [66:62].
- Inverse key step undoes the forward step in reverse order: XOR i, then inverse S-box on the same nibbles, then rotate right 61.
- States:
  - IDLE: `in_ready` = 1. On accept, go to ROUND if encrypting, KEYEXP if decrypting. Round counter i = 1.
  - KEYEXP (decrypt only): apply the forward key step with counter i, once per cycle for i = 1..31. At i = 31, the register holds K32. Also load state ^= K32, set i = 31, go to ROUND.
  - ROUND, encrypt: state <= P(S(state ^ K_i)); key <= forward step(i); i++. After i = 31, go to FINAL.
  - ROUND, decrypt: key <= inverse step(i), exposing K_i; state <= invS(invP(state)) ^ K_i; i--. After i = 1, go to DONE.
  - FINAL (encrypt only): state <= state ^ K32, go to DONE.
  - DONE: `out_valid` = 1 and `data_out` = state. On `out_ready`, go to IDLE.
- The round counter is 5 bits wide, only values 1..31 are used, and it never wraps.
- `in_valid` is ignored outside IDLE. A job cannot be accepted in the same cycle the previous result is taken; `in_ready` rises on the edge after the DONE→IDLE transition.

## Timing
- Reset values:
  - state = IDLE;
  - `in_ready` = 1;
  - `out_valid` = 0;
  - `busy` = 0;
  - `data_out` = 0;
  - all internal state and key registers cleared.
- Reset asserted mid-job aborts the job immediately. No result is produced for it.
- Accept at edge T:
  - encrypt: `out_valid` rises after edge T+32 (31 ROUND cycles + 1 FINAL);
  - decrypt: `out_valid` rises after edge T+62 (31 KEYEXP cycles + 31 ROUND cycles).
- `out_valid` is held with `data_out` constant for as many cycles as `out_ready` stays low.
- Throughput with `out_ready` tied high:
  - encrypt: one block per 34 cycles;
  - decrypt: one block per 64 cycles.

## Structure
- `present_pkg` holds:
  - BLOCK_SIZE = 64 and NUM_ROUNDS = 31;
  - the state enum (IDLE, KEYEXP, ROUND, FINAL, DONE);
  - S-box and inverse S-box functions;
  - P-layer and inverse P-layer functions.
- One sub-module, `present_key_step`: combinational forward or inverse key update, parametrised by KEY_SIZE, with inputs key, counter and direction.
- `present_codec` contains the FSM, the round counter, the state and key registers, and the handshake logic.

## Test plan
- KEY_SIZE=80, encrypt, key 0, pt 0 → `data_out` 5579C1387B228445, exactly 32 cycles after accept.
- KEY_SIZE=80, encrypt, key all-ones, pt all-ones → 3333DCD3213210D2. Decrypt of 3333DCD3213210D2 with the same key → FFFFFFFFFFFFFFFF, exactly 62 cycles after accept.
- KEY_SIZE=128, encrypt, key 0, pt 0 → 96DB702A2E6900AF. Decrypting that value returns 0.
- Back-pressure: hold `out_ready` low for 10 cycles in DONE.
  - `data_out` stays constant and `in_ready` stays low.
  - `in_valid` pulses in that window are not accepted.
  - One cycle after `out_ready`, `in_ready` = 1.
- Pull `Reset` low at round 15:
  - all outputs return to reset values asynchronously;
  - a fresh job after release produces the correct known-answer result;
  - input changes after accept do not affect the result.
